// File: rtl/serial_frame_tx_pkg.sv
// rtl/serial_frame_tx_pkg.sv - shared line-format constants and state type for the serial frame link
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_PAYLOAD,
    ST_GAP
  } state_e;

  localparam int         SYNC_W_DEF     = 4;
  localparam logic [3:0] SYNC_DEF       = 4'b1101;
  localparam int         LEN_W_DEF      = 3;
  localparam int         DATA_W_DEF     = 8;
  localparam int         GAP_CYCLES_DEF = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_frame_tx_shift_reg.sv
// rtl/serial_frame_tx_shift_reg.sv - loadable MSB-first parallel-in/serial-out shifter
// A load of width N places din_i[N-1:0] at the top so the next N shifts emit it MSB first.
module frame_shift_reg #(
  parameter int W    = 8,
  parameter int WS_W = $clog2(W) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            shift_i,
  input  logic [WS_W-1:0] width_i,
  input  logic [W-1:0]    din_i,
  output logic            msb_o
);

  logic [W-1:0]    sr_q;
  logic [WS_W-1:0] shamt;

  assign shamt = WS_W'(W) - width_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i << shamt;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], 1'b0};
    end
  end

  assign msb_o = sr_q[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - serial frame transmitter: sync, length, payload, idle gap on one line
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int                SYNC_W     = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC       = SYNC_DEF,
  parameter int                LEN_W      = LEN_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int SR_W  = max3(SYNC_W, LEN_W, DATA_W);
  localparam int CNT_W = $clog2(SR_W) + 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] LEN_LAST  = CNT_W'(LEN_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic              accept;
  logic              cnt_zero;
  logic              sr_load;
  logic              sr_shift;
  logic [CNT_W-1:0]  sr_width;
  logic [SR_W-1:0]   sr_din;
  logic              sr_msb;

  assign accept   = start & ready_q;
  assign cnt_zero = (cnt_q == '0);

  // The shifter is reloaded on the same edge the FSM changes phase; loading
  // zero on gap entry keeps the line low until the next frame's sync load.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_width = '0;
    sr_din   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sr_load  = 1'b1;
          sr_din   = SR_W'(SYNC);
          sr_width = CNT_W'(SYNC_W);
        end
      end
      ST_SYNC: begin
        if (cnt_zero) begin
          sr_load  = 1'b1;
          sr_din   = SR_W'(len_q);
          sr_width = CNT_W'(LEN_W);
        end else begin
          sr_shift = 1'b1;
        end
      end
      ST_LEN: begin
        if (cnt_zero) begin
          sr_load = 1'b1;
          if (len_q != '0) begin
            sr_din   = SR_W'(data_q);
            sr_width = CNT_W'(len_q);
          end else begin
            sr_width = CNT_W'(SR_W);
          end
        end else begin
          sr_shift = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (cnt_zero) begin
          sr_load  = 1'b1;
          sr_width = CNT_W'(SR_W);
        end else begin
          sr_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  frame_shift_reg #(
    .W    (SR_W),
    .WS_W (CNT_W)
  ) u_shift (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .width_i (sr_width),
    .din_i   (sr_din),
    .msb_o   (sr_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_SYNC;
            cnt_q   <= SYNC_LAST;
            len_q   <= len;
            data_q  <= data;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (cnt_zero) begin
            state_q <= ST_LEN;
            cnt_q   <= LEN_LAST;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_LEN: begin
          if (cnt_zero) begin
            if (len_q != '0) begin
              state_q <= ST_PAYLOAD;
              cnt_q   <= CNT_W'(len_q) - CNT_W'(1);
            end else begin
              state_q <= ST_GAP;
              cnt_q   <= GAP_LAST;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (cnt_zero) begin
            state_q <= ST_GAP;
            cnt_q   <= GAP_LAST;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out   = sr_msb;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - self-checking bench for serial_frame_tx
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] len;
  logic [7:0] data;
  logic       ready;
  logic       out;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  serial_frame_tx dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len   (len),
    .data  (data),
    .ready (ready),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] d;
    int         exp_done;
    int         exp_ready;
    bit         poke;
  } vec_t;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("wait_ready", t, {31'd0, ready}, 32'd1);
  endtask

  // Expected line contents (frame bits then gap zeros) built straight from the format rules.
  task automatic build_line(input int n, input logic [7:0] d, output int bits[$]);
    logic [3:0] sp;
    logic [2:0] ln;
    sp = 4'b1101;
    ln = 3'(n);
    bits = {};
    for (int i = 3; i >= 0; i--) bits.push_back(int'(sp[i]));
    for (int i = 2; i >= 0; i--) bits.push_back(int'(ln[i]));
    for (int i = n - 1; i >= 0; i--) bits.push_back(int'(d[i]));
    for (int g = 0; g < 2; g++) bits.push_back(0);
  endtask

  // Call just after a negedge; returns just after the negedge of the ready cycle.
  task automatic run_frame(input string name, input int n, input logic [7:0] d,
                           input int exp_done, input int exp_ready, input bit poke);
    int         bits[$];
    logic [3:0] exp;
    build_line(n, d, bits);
    wait_ready();
    start = 1'b1;
    len   = 3'(n);
    data  = d;
    @(posedge clk);
    for (int k = 1; k <= exp_ready; k++) begin
      @(negedge clk);
      if (k < exp_ready)
        exp = {bits[k-1] != 0, 1'b1, 1'b0, k == exp_done};
      else
        exp = 4'b0010;
      check(name, k, {28'd0, out, busy, ready, done}, {28'd0, exp});
      if (k == 1) begin
        start = 1'b0;
        len   = 3'($urandom);
        data  = 8'($urandom);
      end
      if (poke && k == 3) begin
        start = 1'b1;
        len   = 3'd2;
        data  = ~d;
      end
      if (poke && k == 5) start = 1'b0;
    end
    if (poke) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        check({name, "_after"}, k, {29'd0, out, busy, ready}, 32'b001);
      end
    end
  endtask

  vec_t vecs[6];
  int   bb[8];

  initial begin
    vecs[0] = '{n: 5, d: 8'hA5, exp_done: 13, exp_ready: 15, poke: 1'b0};
    vecs[1] = '{n: 0, d: 8'hFF, exp_done: 8,  exp_ready: 10, poke: 1'b0};
    vecs[2] = '{n: 7, d: 8'h80, exp_done: 15, exp_ready: 17, poke: 1'b0};
    vecs[3] = '{n: 3, d: 8'h3C, exp_done: 11, exp_ready: 13, poke: 1'b1};
    vecs[4] = '{n: 1, d: 8'h01, exp_done: 9,  exp_ready: 11, poke: 1'b0};
    vecs[5] = '{n: 6, d: 8'h2D, exp_done: 14, exp_ready: 16, poke: 1'b1};
    bb = '{1, 1, 0, 1, 0, 0, 1, 1};

    rst   = 1'b0;
    start = 1'b0;
    len   = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset_state", 0, {28'd0, out, busy, ready, done}, 32'b0010);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].d,
                vecs[i].exp_done, vecs[i].exp_ready, vecs[i].poke);

    for (int i = 0; i < 20; i++) begin
      int         n;
      logic [7:0] d;
      n = int'($urandom_range(0, 7));
      d = 8'($urandom);
      run_frame($sformatf("rnd%0d", i), n, d, 8 + n, 10 + n, 1'b0);
    end

    // start held high: frames repeat every 11 cycles (8 bits, 2 gap, 1 idle)
    wait_ready();
    start = 1'b1;
    len   = 3'd1;
    data  = 8'd1;
    @(posedge clk);
    for (int k = 1; k <= 33; k++) begin
      int p;
      @(negedge clk);
      p = (k - 1) % 11;
      check("b2b", k, {29'd0, out, ready, done},
            {29'd0, (p < 8) ? bb[p] != 0 : 1'b0, p == 10, p == 8});
      if (k == 33) start = 1'b0;
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("b2b_stop", k, {29'd0, out, busy, ready}, 32'b001);
    end

    // asynchronous reset in the middle of the payload
    wait_ready();
    start = 1'b1;
    len   = 3'd6;
    data  = 8'hB7;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    check("pre_reset_payload", 9, {31'd0, out}, {31'd0, 1'b1});
    #2 rst = 1'b0;
    #1 check("async_reset", 0, {28'd0, out, busy, ready, done}, 32'b0010);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("in_reset", k, {28'd0, out, busy, ready, done}, 32'b0010);
    end
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("post_reset", k, {28'd0, out, busy, ready, done}, 32'b0010);
    end
    run_frame("after_reset", 4, 8'h96, 12, 14, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
